// File: rtl/systolic_operand_feeder.sv
// systolic_operand_feeder: per-lane operand FIFO bank feeding one systolic array edge.
// The host fills lanes element-interleaved (elem0 of lanes 0..n-1, then elem1, ...).
// The array controller then pops one element per selected lane on each `next`;
// unselected lanes output zero, which produces the diagonal skew and padding.
// Latency: data_out/valid_out are registered, one clock after `next`.
// Backpressure: wr_ready is high only in FILL. Pops are never stalled; an empty
//   selected lane yields zero with valid_out low.
// Ports:
//   clk, reset (sync, active-high)
//   fill_start/n_lanes/len  start a fill; n_lanes clamped to SIZE, len to DEPTH
//   wr_en/wr_data/wr_ready  element write port
//   flush                   abort from any state, empties every lane
//   next/memsel             pop strobe and per-lane select from the array controller
//   data_out/valid_out      lane i at [i*DW +: DW] / bit i
//   armed, drained          fill complete / one-cycle pulse when the last element leaves
//   underflow               sticky flag for a selected pop from an empty lane
// Optional feature: define FEEDER_UNDERFLOW_CHECK_EN to build underflow detection;
//   otherwise underflow is tied low.
module systolic_operand_feeder #(
  parameter int SIZE  = 16,
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fill_start,
  input  logic [$clog2(SIZE):0]  n_lanes,
  input  logic [$clog2(DEPTH):0] len,
  input  logic                   wr_en,
  input  logic [DW-1:0]          wr_data,
  output logic                   wr_ready,
  input  logic                   flush,
  input  logic                   next,
  input  logic [SIZE-1:0]        memsel,
  output logic [SIZE*DW-1:0]     data_out,
  output logic [SIZE-1:0]        valid_out,
  output logic                   armed,
  output logic                   drained,
  output logic                   underflow
);

  localparam int LW = $clog2(SIZE) + 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [LW-1:0] SIZE_C   = LW'(SIZE);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_ARMED  = 2'd2;
  localparam logic [1:0] S_STREAM = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] nl_q, nl_d;
  logic [CW-1:0] len_q, len_d;
  logic [LW-1:0] lane_cnt_q, lane_cnt_d;
  logic [CW-1:0] elem_cnt_q, elem_cnt_d;

  logic [SIZE*DW-1:0] data_q;
  logic [SIZE-1:0]    valid_q;
  logic               drained_q;

  logic               wr_fire;
  logic               pop_fire;
  logic [SIZE-1:0]    lane_has;
  logic [SIZE-1:0]    lane_one;
  logic [SIZE-1:0]    pop_lane;
  logic [SIZE*DW-1:0] pop_dat;
  logic               all_empty_after;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // flush wins over any write or pop in the same cycle
  assign wr_ready = (state_q == S_FILL);
  assign wr_fire  = wr_en && wr_ready && !flush;
  assign pop_fire = next && !flush && ((state_q == S_ARMED) || (state_q == S_STREAM));

  // Per-lane FIFO storage and pointers
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          lane_wr;

    assign lane_wr     = wr_fire && (lane_cnt_q == LW'(i));
    assign lane_has[i] = (cnt_q != '0);
    assign lane_one[i] = (cnt_q == CW'(1));
    assign pop_lane[i] = pop_fire && memsel[i] && lane_has[i];
    assign pop_dat[i*DW +: DW] = pop_lane[i] ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk) begin
      if (lane_wr) begin
        mem_q[wr_ptr_q] <= wr_data;
      end
    end

    // Writes only happen in FILL and pops only in ARMED/STREAM, so the
    // count never sees an increment and decrement together.
    always_ff @(posedge clk) begin
      if (reset || flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (lane_wr) begin
          wr_ptr_q <= ptr_inc(wr_ptr_q);
          cnt_q    <= cnt_q + 1'b1;
        end else if (pop_lane[i]) begin
          rd_ptr_q <= ptr_inc(rd_ptr_q);
          cnt_q    <= cnt_q - 1'b1;
        end
      end
    end
  end

  // Lanes beyond n_lanes are never written, so checking every lane is the
  // same as checking the used ones.
  assign all_empty_after = &(~lane_has | (lane_one & pop_lane));

  always_comb begin
    state_d    = state_q;
    nl_d       = nl_q;
    len_d      = len_q;
    lane_cnt_d = lane_cnt_q;
    elem_cnt_d = elem_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (fill_start && (n_lanes != '0) && (len != '0)) begin
          state_d    = S_FILL;
          nl_d       = (n_lanes > SIZE_C) ? SIZE_C : n_lanes;
          len_d      = (len > DEPTH_C) ? DEPTH_C : len;
          lane_cnt_d = '0;
          elem_cnt_d = '0;
        end
      end
      S_FILL: begin
        if (wr_fire) begin
          if (lane_cnt_q == nl_q - LW'(1)) begin
            lane_cnt_d = '0;
            elem_cnt_d = elem_cnt_q + 1'b1;
            if (elem_cnt_q == len_q - CW'(1)) begin
              state_d = S_ARMED;
            end
          end else begin
            lane_cnt_d = lane_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        // ARMED and STREAM: the arming pulse is itself a pop
        if (pop_fire) begin
          state_d = all_empty_after ? S_IDLE : S_STREAM;
        end
      end
    endcase
    if (flush) begin
      state_d    = S_IDLE;
      lane_cnt_d = '0;
      elem_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      nl_q       <= '0;
      len_q      <= '0;
      lane_cnt_q <= '0;
      elem_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      nl_q       <= nl_d;
      len_q      <= len_d;
      lane_cnt_q <= lane_cnt_d;
      elem_cnt_q <= elem_cnt_d;
    end
  end

  // Outputs hold between pops so the array load cycle sees stable data
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      data_q    <= '0;
      valid_q   <= '0;
      drained_q <= 1'b0;
    end else begin
      drained_q <= pop_fire && all_empty_after;
      if (pop_fire) begin
        data_q  <= pop_dat;
        valid_q <= pop_lane;
      end
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign drained   = drained_q;
  assign armed     = (state_q == S_ARMED);

`ifdef FEEDER_UNDERFLOW_CHECK_EN
  logic underflow_q;
  logic uf_hit;

  assign uf_hit = pop_fire && |(memsel & ~lane_has);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      underflow_q <= 1'b0;
    end else if (fill_start && (state_q == S_IDLE)) begin
      underflow_q <= 1'b0;
    end else if (uf_hit) begin
      underflow_q <= 1'b1;
    end
  end

  assign underflow = underflow_q;
`else
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Testbench for systolic_operand_feeder: directed scenarios plus randomized
// fills/pops checked against a queue-per-lane reference model.
module tb_systolic_operand_feeder;

  localparam int SIZE  = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int NLW   = $clog2(SIZE) + 1;
  localparam int LNW   = $clog2(DEPTH) + 1;
`ifdef FEEDER_UNDERFLOW_CHECK_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               fill_start = 1'b0;
  logic [NLW-1:0]     n_lanes = '0;
  logic [LNW-1:0]     len = '0;
  logic               wr_en = 1'b0;
  logic [DW-1:0]      wr_data = '0;
  logic               wr_ready;
  logic               flush = 1'b0;
  logic               next = 1'b0;
  logic [SIZE-1:0]    memsel = '0;
  logic [SIZE*DW-1:0] data_out;
  logic [SIZE-1:0]    valid_out;
  logic               armed;
  logic               drained;
  logic               underflow;

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per lane plus the expected registered outputs
  logic [DW-1:0]      mq [SIZE][$];
  logic [SIZE*DW-1:0] exp_do;
  logic [SIZE-1:0]    exp_vo;
  logic               exp_uf;
  bit                 active;

  systolic_operand_feeder #(.SIZE(SIZE), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .fill_start(fill_start), .n_lanes(n_lanes),
    .len(len), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .flush(flush), .next(next), .memsel(memsel), .data_out(data_out),
    .valid_out(valid_out), .armed(armed), .drained(drained), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < SIZE; i++) mq[i].delete();
    exp_do = '0;
    exp_vo = '0;
    exp_uf = 1'b0;
    active = 1'b0;
  endtask

  function automatic logic uf_req();
    return UF_EN ? exp_uf : 1'b0;
  endfunction

  task automatic do_fill(input int n, input int l, input bit fixed, input string nm);
    int nn, ll;
    logic [DW-1:0] d;
    fill_start = 1'b1;
    n_lanes = NLW'(n);
    len = LNW'(l);
    tick();
    fill_start = 1'b0;
    exp_uf = 1'b0;
    if (n == 0 || l == 0) begin
      checks++;
      if (wr_ready !== 1'b0 || armed !== 1'b0) begin
        errors++;
        $display("FAIL %s_zero_arg: wr_ready=%b armed=%b, required 0 0", nm, wr_ready, armed);
      end
      return;
    end
    nn = (n > SIZE) ? SIZE : n;
    ll = (l > DEPTH) ? DEPTH : l;
    checks++;
    if (wr_ready !== 1'b1 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: wr_ready=%b underflow=%b, required 1 0", nm, wr_ready, underflow);
    end
    for (int e = 0; e < ll; e++) begin
      for (int k = 0; k < nn; k++) begin
        d = fixed ? DW'(((k + 1) << 4) | (e + 1)) : DW'($urandom);
        wr_en = 1'b1;
        wr_data = d;
        mq[k].push_back(d);
        if (k == nn - 1 && e == ll - 1) begin
          checks++;
          if (armed !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_pre_last: armed=%b wr_ready=%b, required 0 1", nm, armed, wr_ready);
          end
        end
        tick();
      end
    end
    wr_en = 1'b0;
    active = 1'b1;
    checks++;
    if (armed !== 1'b1 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_armed: armed=%b wr_ready=%b, required 1 0", nm, armed, wr_ready);
    end
  endtask

  task automatic do_pop(input logic [SIZE-1:0] sel, input string nm);
    logic drn;
    drn = 1'b0;
    if (active) begin
      for (int i = 0; i < SIZE; i++) begin
        if (sel[i] && mq[i].size() > 0) begin
          exp_do[i*DW +: DW] = mq[i].pop_front();
          exp_vo[i] = 1'b1;
        end else begin
          exp_do[i*DW +: DW] = '0;
          exp_vo[i] = 1'b0;
          if (sel[i]) exp_uf = 1'b1;
        end
      end
      drn = 1'b1;
      for (int i = 0; i < SIZE; i++) if (mq[i].size() != 0) drn = 1'b0;
      if (drn) active = 1'b0;
    end
    next = 1'b1;
    memsel = sel;
    tick();
    next = 1'b0;
    memsel = '0;
    checks++;
    if (data_out !== exp_do) begin
      errors++;
      $display("FAIL %s_data: got %h, required %h", nm, data_out, exp_do);
    end
    checks++;
    if (valid_out !== exp_vo) begin
      errors++;
      $display("FAIL %s_valid: got %h, required %h", nm, valid_out, exp_vo);
    end
    checks++;
    if (drained !== drn) begin
      errors++;
      $display("FAIL %s_drained: got %b, required %b", nm, drained, drn);
    end
    checks++;
    if (underflow !== uf_req()) begin
      errors++;
      $display("FAIL %s_underflow: got %b, required %b", nm, underflow, uf_req());
    end
  endtask

  task automatic idle_check(input string nm);
    tick();
    checks++;
    if (data_out !== exp_do || valid_out !== exp_vo || drained !== 1'b0) begin
      errors++;
      $display("FAIL %s: data=%h valid=%h drained=%b, required %h %h 0",
               nm, data_out, valid_out, drained, exp_do, exp_vo);
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_clear();
  endtask

  task automatic check_all_zero(input string nm);
    checks++;
    if (wr_ready !== 1'b0 || armed !== 1'b0 || drained !== 1'b0 || underflow !== 1'b0 ||
        data_out !== '0 || valid_out !== '0) begin
      errors++;
      $display("FAIL %s: wr_ready=%b armed=%b drained=%b underflow=%b data=%h valid=%h, required all 0",
               nm, wr_ready, armed, drained, underflow, data_out, valid_out);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_clear();
    check_all_zero("reset_state");
  endtask

  task automatic test_basic_fill();
    do_fill(2, 2, 1'b1, "basic");
    do_pop(16'h0001, "skew1");
    checks++;
    if (data_out[7:0] !== 8'h11 || data_out[15:8] !== 8'h00) begin
      errors++;
      $display("FAIL skew1_const: lane0=%h lane1=%h, required 11 00", data_out[7:0], data_out[15:8]);
    end
    do_pop(16'h0003, "skew2");
    checks++;
    if (data_out[7:0] !== 8'h12 || data_out[15:8] !== 8'h21) begin
      errors++;
      $display("FAIL skew2_const: lane0=%h lane1=%h, required 12 21", data_out[7:0], data_out[15:8]);
    end
    do_pop(16'h0002, "skew3");
    checks++;
    if (data_out[15:8] !== 8'h22 || drained !== 1'b1) begin
      errors++;
      $display("FAIL skew3_const: lane1=%h drained=%b, required 22 1", data_out[15:8], drained);
    end
    idle_check("drained_width");
    checks++;
    if (armed !== 1'b0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: armed=%b wr_ready=%b, required 0 0", armed, wr_ready);
    end
    // next in IDLE is ignored; outputs must hold the last popped values
    do_pop(16'hFFFF, "idle_next");
  endtask

  task automatic test_underflow();
    do_fill(2, 1, 1'b0, "uf");
    do_pop(16'h0001, "uf_pop1");
    do_pop(16'h0001, "uf_pop2");
    checks++;
    if (data_out[7:0] !== 8'h00 || valid_out[0] !== 1'b0 || underflow !== UF_EN) begin
      errors++;
      $display("FAIL uf_empty_lane: lane0=%h valid=%b underflow=%b, required 00 0 %b",
               data_out[7:0], valid_out[0], underflow, UF_EN);
    end
    // fill_start outside IDLE must not reopen the write port
    fill_start = 1'b1;
    n_lanes = NLW'(1);
    len = LNW'(1);
    tick();
    fill_start = 1'b0;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL uf_busy_fill_start: wr_ready=%b, required 0", wr_ready);
    end
    do_pop(16'h0004, "uf_unused_lane");
    do_pop(16'h0002, "uf_drain");
    do_flush();
    check_all_zero("uf_flush");
  endtask

  task automatic test_flush_mid_fill();
    fill_start = 1'b1;
    n_lanes = NLW'(2);
    len = LNW'(4);
    tick();
    fill_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'b1;
      wr_data = DW'($urandom);
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    model_clear();
    check_all_zero("flush_mid_fill");
    fill_start = 1'b1;
    n_lanes = NLW'(1);
    len = LNW'(1);
    tick();
    fill_start = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'hAB;
    mq[0].push_back(8'hAB);
    tick();
    wr_en = 1'b0;
    active = 1'b1;
    checks++;
    if (armed !== 1'b1) begin
      errors++;
      $display("FAIL flush_refill_armed: armed=%b, required 1", armed);
    end
    do_pop(16'h0001, "flush_refill_pop");
    checks++;
    if (data_out[7:0] !== 8'hAB) begin
      errors++;
      $display("FAIL flush_refill_const: lane0=%h, required ab", data_out[7:0]);
    end
  endtask

  task automatic test_reset_mid_stream();
    do_fill(4, 4, 1'b0, "rst");
    do_pop(16'h000F, "rst_pop1");
    do_pop(16'h0005, "rst_pop2");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    check_all_zero("reset_mid_stream");
    do_pop(16'hFFFF, "rst_next_ignored");
  endtask

  task automatic test_clamp();
    do_fill(SIZE + 1, 0, 1'b0, "clamp_zero");
    idle_check("clamp_zero_idle");
    do_fill(SIZE + 1, 1, 1'b0, "clamp_size");
    do_pop(16'hFFFF, "clamp_pop");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      do_fill($urandom_range(1, SIZE + 1), $urandom_range(1, DEPTH + 1), 1'b0, "rnd_fill");
      for (int p = 0; p < 400 && active; p++) begin
        if ($urandom_range(0, 3) == 0) idle_check("rnd_hold");
        do_pop(SIZE'($urandom), "rnd_pop");
      end
      checks++;
      if (active) begin
        errors++;
        $display("FAIL rnd_drain_timeout: lanes not drained within 400 pops, required drained");
        do_flush();
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic_fill();
    test_underflow();
    test_flush_mid_fill();
    test_reset_mid_stream();
    test_clamp();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
